// File: rtl/masked_dot_acc64.sv
// masked_dot_acc64: sequential 64-bit multiply-accumulate producing a masked pre-activation.
//
// Accepts VEC_LEN (x, w) element pairs per vector, accumulates sum(x_i * w_i) mod 2^64 and
// emits (sum - mask) mod 2^64, where the mask is sampled on the first beat of each vector.
// The unmasked sum is never driven on any output.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous reset, active-low
//   in_valid   in   element pair valid
//   in_ready   out  element pair accepted this cycle when in_valid is also high
//   in_x       in   64-bit evaluator operand
//   in_w       in   64-bit weight operand
//   g_mask     in   64-bit additive mask, sampled on the first beat of a vector
//   out_valid  out  masked result valid
//   out_ready  in   downstream accepts the result
//   out_data   out  (acc - mask) mod 2^64, stable while out_valid is high
//   busy       out  a vector is in progress or a result is pending
module masked_dot_acc64 #(
    parameter int unsigned VEC_LEN = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_x,
    input  logic [63:0] in_w,
    input  logic [63:0] g_mask,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StAcc, StOut} state_e;

    localparam logic [CNT_W-1:0] LastCnt    = CNT_W'(VEC_LEN - 1);
    localparam bit               SingleBeat = (VEC_LEN == 1);

    state_e      state_q, state_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] mask_q, mask_d;
    logic [63:0] out_data_q, out_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        out_valid_q, out_valid_d;
    logic        busy_q, busy_d;

    logic [63:0] prod;
    logic [63:0] acc_sum;
    logic        beat;

    // Low 64 bits of the product are identical for signed and unsigned operands.
    assign prod    = in_x * in_w;
    assign acc_sum = acc_q + prod;

    // Gated by rst_n so no beat looks acceptable while reset is held.
    assign in_ready = rst_n && (state_q != StOut);
    assign beat     = in_valid && in_ready;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mask_d      = mask_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        busy_d      = busy_q;

        case (state_q)
            StIdle: begin
                if (beat) begin
                    acc_d  = prod;
                    mask_d = g_mask;
                    cnt_d  = CNT_W'(1);
                    busy_d = 1'b1;
                    if (SingleBeat) begin
                        state_d     = StOut;
                        out_valid_d = 1'b1;
                        out_data_d  = prod - g_mask;
                    end else begin
                        state_d = StAcc;
                    end
                end
            end
            StAcc: begin
                if (beat) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LastCnt) begin
                        state_d     = StOut;
                        out_valid_d = 1'b1;
                        // Result is registered here so it stays frozen under backpressure.
                        out_data_d  = acc_sum - mask_q;
                    end
                end
            end
            StOut: begin
                if (out_ready) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                    cnt_d       = '0;
                    acc_d       = '0;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            mask_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mask_q      <= mask_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
        end
    end

endmodule
